// File: rtl/serial_display_pkg.sv
// Shared constants for the 7-segment serial display receiver.
package serial_display_pkg;

    localparam int FRAME_BITS = 48;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] DIGIT_ERR   = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT,
        ST_ERROR
    } rx_state_e;

endpackage

// File: rtl/serial_display_rx_seg7_to_bcd.sv
// Combinational segment pattern {g..a} to BCD digit; blank is legal, anything else flags invalid.
module seg7_to_bcd
    import serial_display_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic [3:0] digit_o
);

    always_comb begin
        valid_o = 1'b1;
        digit_o = DIGIT_ERR;
        case (seg_i)
            SEG_0:     digit_o = 4'd0;
            SEG_1:     digit_o = 4'd1;
            SEG_2:     digit_o = 4'd2;
            SEG_3:     digit_o = 4'd3;
            SEG_4:     digit_o = 4'd4;
            SEG_5:     digit_o = 4'd5;
            SEG_6:     digit_o = 4'd6;
            SEG_7:     digit_o = 4'd7;
            SEG_8:     digit_o = 4'd8;
            SEG_9:     digit_o = 4'd9;
            SEG_BLANK: digit_o = DIGIT_BLANK;
            default: begin
                valid_o = 1'b0;
                digit_o = DIGIT_ERR;
            end
        endcase
    end

endmodule

// File: rtl/serial_display_rx.sv
// Oversampling receiver for the 3-wire display shift bus: deserializes a frame,
// commits it on the latch edge and decodes each segment byte to BCD.
//
// state   | meaning
// IDLE    | no bits received since the last commit/error
// SHIFT   | collecting bits, waiting for the latch edge
// COMMIT  | register frame and decoded digits, pulse o_frame_stb
// ERROR   | latch with wrong bit count, pulse o_frame_err, outputs held
module serial_display_rx
    import serial_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int BITS_PER_DIGIT = 8,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset_n,
    input  logic                                 i_en,
    input  logic                                 i_serial_data,
    input  logic                                 i_serial_clk,
    input  logic                                 i_serial_latch,
    output logic [NUM_DIGITS*BITS_PER_DIGIT-1:0] o_frame,
    output logic                                 o_frame_stb,
    output logic                                 o_frame_err,
    output logic [3:0]                           o_hours_msb,
    output logic [3:0]                           o_hours_lsb,
    output logic [3:0]                           o_minutes_msb,
    output logic [3:0]                           o_minutes_lsb,
    output logic [3:0]                           o_seconds_msb,
    output logic [3:0]                           o_seconds_lsb,
    output logic [NUM_DIGITS-1:0]                o_dp,
    output logic                                 o_decode_err
);

    localparam int FW = NUM_DIGITS * BITS_PER_DIGIT;
    localparam int CW = $clog2(FW + 2);

    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic                   clk_prev_q;
    logic                   latch_prev_q;

    rx_state_e                    state_q;
    logic [FW-1:0]                shreg_q;
    logic [FW-1:0]                shreg_d;
    logic [CW-1:0]                cnt_q;
    logic [CW-1:0]                cnt_d;
    logic [FW-1:0]                frame_q;
    logic [NUM_DIGITS-1:0][3:0]   digits_q;
    logic [NUM_DIGITS-1:0]        dp_q;
    logic                         dec_err_q;
    logic                         stb_q;
    logic                         err_q;

    logic                         clk_rise;
    logic                         latch_rise;
    logic                         shift_en;
    logic [NUM_DIGITS-1:0][3:0]   dec_digit;
    logic [NUM_DIGITS-1:0]        dec_valid;
    logic [NUM_DIGITS-1:0]        dp_now;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        seg7_to_bcd u_dec (
            .seg_i   (shreg_q[i*BITS_PER_DIGIT +: 7]),
            .valid_o (dec_valid[i]),
            .digit_o (dec_digit[i])
        );
        assign dp_now[i] = shreg_q[i*BITS_PER_DIGIT + 7];
    end

    // Shift first, so a clock and latch seen in the same cycle count that bit.
    always_comb begin
        clk_rise   = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
        latch_rise = latch_sync_q[SYNC_STAGES-1] & ~latch_prev_q;
        shift_en   = clk_rise & i_en;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        if (shift_en) begin
            shreg_d = {shreg_q[FW-2:0], data_sync_q[SYNC_STAGES-1]};
            if (cnt_q != CW'(FW + 1)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            data_sync_q  <= '0;
            clk_sync_q   <= '0;
            latch_sync_q <= '0;
            clk_prev_q   <= 1'b0;
            latch_prev_q <= 1'b0;
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            frame_q      <= '0;
            digits_q     <= '0;
            dp_q         <= '0;
            dec_err_q    <= 1'b0;
            stb_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], i_serial_data};
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], i_serial_clk};
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], i_serial_latch};
            clk_prev_q   <= clk_sync_q[SYNC_STAGES-1];
            latch_prev_q <= latch_sync_q[SYNC_STAGES-1];
            stb_q        <= 1'b0;
            err_q        <= 1'b0;

            if (!i_en) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_SHIFT: begin
                        shreg_q <= shreg_d;
                        cnt_q   <= cnt_d;
                        if (latch_rise) begin
                            state_q <= (cnt_d == CW'(FW)) ? ST_COMMIT : ST_ERROR;
                        end else if (shift_en) begin
                            state_q <= ST_SHIFT;
                        end
                    end
                    ST_COMMIT: begin
                        frame_q   <= shreg_q;
                        digits_q  <= dec_digit;
                        dp_q      <= dp_now;
                        dec_err_q <= ~&dec_valid;
                        stb_q     <= 1'b1;
                        shreg_q   <= shreg_d;
                        cnt_q     <= shift_en ? CW'(1) : '0;
                        state_q   <= shift_en ? ST_SHIFT : ST_IDLE;
                    end
                    ST_ERROR: begin
                        err_q   <= 1'b1;
                        shreg_q <= shreg_d;
                        cnt_q   <= shift_en ? CW'(1) : '0;
                        state_q <= shift_en ? ST_SHIFT : ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_frame       = frame_q;
    assign o_frame_stb   = stb_q;
    assign o_frame_err   = err_q;
    assign o_hours_msb   = digits_q[5];
    assign o_hours_lsb   = digits_q[4];
    assign o_minutes_msb = digits_q[3];
    assign o_minutes_lsb = digits_q[2];
    assign o_seconds_msb = digits_q[1];
    assign o_seconds_lsb = digits_q[0];
    assign o_dp          = dp_q;
    assign o_decode_err  = dec_err_q;

endmodule
